// File: rtl/axi_slave_shim.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ariane_axi -- minimal AXI4 channel/bundle types (64-bit address and data,
// 4-bit ID) shared by the shim and anything that talks to it.
// ---------------------------------------------------------------------------
package ariane_axi;
    localparam int unsigned IdWidth = 4;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic               lock;
        logic [3:0]         cache;
        logic [2:0]         prot;
        logic [3:0]         qos;
        logic [3:0]         region;
        logic [5:0]         atop;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic               lock;
        logic [3:0]         cache;
        logic [2:0]         prot;
        logic [3:0]         qos;
        logic [3:0]         region;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        data;
        logic [1:0]         resp;
        logic               last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

// ---------------------------------------------------------------------------
// axi_slave_shim -- converts AXI4 bursts into single-beat memory requests,
// one transaction at a time. Writes win over reads when both arrive together.
//   clk_i/rst_ni  : clock, asynchronous active-low reset
//   axi_req_i     : AXI request bundle from the upstream master
//   axi_resp_o    : AXI response bundle to the upstream master
//   mem_req_o     : memory request strobe, held until mem_gnt_i
//   mem_we_o      : 1 = write, 0 = read
//   mem_addr_o    : byte address of the current beat
//   mem_wdata_o   : write data (from W)
//   mem_be_o      : byte enables (W strobe, all ones for reads)
//   mem_rdata_i   : read data, valid one cycle after a granted read
// ---------------------------------------------------------------------------
module axi_slave_shim #(
    parameter int unsigned AxiIdWidth = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [63:0]       mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    input  logic [63:0]       mem_rdata_i
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE      = 3'd1;
    localparam logic [2:0] WRITE_RESP = 3'd2;
    localparam logic [2:0] READ       = 3'd3;
    localparam logic [2:0] READ_WAIT  = 3'd4;
    localparam logic [2:0] READ_RESP  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state_r;
    logic [AxiIdWidth-1:0] id_r;
    logic [63:0]           addr_r;
    logic [7:0]            len_r;
    logic [2:0]            size_r;
    logic [5:0]            atop_r;
    logic [7:0]            cnt_r;
    logic                  err_r;
    logic [63:0]           rdata_r;

    logic        aw_hs_s;
    logic        ar_hs_s;
    logic        w_fire_s;
    logic        last_beat_s;
    logic [63:0] addr_step_s;
    logic        unused_s;

    // Handshake and burst-position decode shared by the FSM and the outputs.
    assign aw_hs_s     = (state_r == IDLE) && axi_req_i.aw_valid;
    assign ar_hs_s     = (state_r == IDLE) && axi_req_i.ar_valid && !axi_req_i.aw_valid;
    assign w_fire_s    = (state_r == WRITE) && axi_req_i.w_valid && mem_gnt_i;
    assign last_beat_s = (cnt_r == len_r);
    // Every burst type is handled as INCR; address arithmetic wraps at 2^64.
    assign addr_step_s = 64'd1 << size_r;

    // burst/lock/cache/prot/qos/region carry no meaning for this memory.
    assign unused_s = ^{axi_req_i.aw.burst, axi_req_i.aw.lock, axi_req_i.aw.cache,
                        axi_req_i.aw.prot, axi_req_i.aw.qos, axi_req_i.aw.region,
                        axi_req_i.ar.burst, axi_req_i.ar.lock, axi_req_i.ar.cache,
                        axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region};

    // Transaction FSM plus the latched request fields, beat counter and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            id_r    <= '0;
            addr_r  <= 64'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            atop_r  <= 6'd0;
            cnt_r   <= 8'd0;
            err_r   <= 1'b0;
            rdata_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        id_r    <= AxiIdWidth'(axi_req_i.aw.id);
                        addr_r  <= axi_req_i.aw.addr;
                        len_r   <= axi_req_i.aw.len;
                        size_r  <= axi_req_i.aw.size;
                        atop_r  <= axi_req_i.aw.atop;
                        cnt_r   <= 8'd0;
                        state_r <= WRITE;
                    end else if (ar_hs_s) begin
                        id_r    <= AxiIdWidth'(axi_req_i.ar.id);
                        addr_r  <= axi_req_i.ar.addr;
                        len_r   <= axi_req_i.ar.len;
                        size_r  <= axi_req_i.ar.size;
                        cnt_r   <= 8'd0;
                        state_r <= READ;
                    end
                end
                WRITE: begin
                    if (w_fire_s) begin
                        addr_r <= addr_r + addr_step_s;
                        cnt_r  <= cnt_r + 8'd1;
                        // The counter ends the burst; a misplaced w.last only flags an error.
                        if (axi_req_i.w.last != last_beat_s) begin
                            err_r <= 1'b1;
                        end
                        if (last_beat_s) begin
                            state_r <= WRITE_RESP;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (axi_req_i.b_ready) begin
                        err_r   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (mem_gnt_i) begin
                        state_r <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    rdata_r <= mem_rdata_i;
                    state_r <= READ_RESP;
                end
                READ_RESP: begin
                    if (axi_req_i.r_ready) begin
                        if (last_beat_s) begin
                            state_r <= IDLE;
                        end else begin
                            addr_r  <= addr_r + addr_step_s;
                            cnt_r   <= cnt_r + 8'd1;
                            state_r <= READ;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // State-decoded outputs; anything the current state does not drive is zero.
    always_comb begin
        axi_resp_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 64'd0;
        mem_wdata_o = 64'd0;
        mem_be_o    = 8'd0;
        case (state_r)
            IDLE: begin
                axi_resp_o.aw_ready = axi_req_i.aw_valid;
                axi_resp_o.ar_ready = axi_req_i.ar_valid & ~axi_req_i.aw_valid;
            end
            WRITE: begin
                mem_req_o          = axi_req_i.w_valid;
                mem_we_o           = 1'b1;
                mem_addr_o         = addr_r;
                mem_wdata_o        = axi_req_i.w.data;
                mem_be_o           = axi_req_i.w.strb;
                axi_resp_o.w_ready = axi_req_i.w_valid & mem_gnt_i;
            end
            WRITE_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = ariane_axi::IdWidth'(id_r);
                axi_resp_o.b.resp  = (err_r || (atop_r != 6'd0)) ? RESP_SLVERR : RESP_OKAY;
            end
            READ: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b0;
                mem_addr_o = addr_r;
                mem_be_o   = 8'hFF;
            end
            READ_WAIT: begin
                mem_req_o = 1'b0;
            end
            READ_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.id    = ariane_axi::IdWidth'(id_r);
                axi_resp_o.r.data  = rdata_r;
                axi_resp_o.r.resp  = RESP_OKAY;
                axi_resp_o.r.last  = last_beat_s;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_axi_slave_shim.sv
`timescale 1ns/1ps
// Directed bench for axi_slave_shim: a small memory model answers reads with
// (address ^ RD_KEY) one cycle after grant and logs every granted access.
module tb_axi_slave_shim;
    localparam logic [63:0] RD_KEY = 64'hA5A5_0000_0000_5A5A;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;
    logic              mem_req, mem_gnt, mem_we;
    logic [63:0]       mem_addr, mem_wdata, mem_rdata;
    logic [7:0]        mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [7:0]  wr_be_q[$];
    logic [63:0] rd_addr_q[$];

    always #5 clk = ~clk;

    axi_slave_shim #(.AxiIdWidth(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .axi_req_i   (req),
        .axi_resp_o  (resp),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    // Memory model: log granted accesses, return read data one cycle later.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wr_be_q.push_back(mem_be);
            end else begin
                rd_addr_q.push_back(mem_addr);
                mem_rdata <= mem_addr ^ RD_KEY;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check_eq({tag, "_aw_ready"}, 64'(resp.aw_ready), 64'd0);
        check_eq({tag, "_ar_ready"}, 64'(resp.ar_ready), 64'd0);
        check_eq({tag, "_w_ready"},  64'(resp.w_ready),  64'd0);
        check_eq({tag, "_b_valid"},  64'(resp.b_valid),  64'd0);
        check_eq({tag, "_r_valid"},  64'(resp.r_valid),  64'd0);
        check_eq({tag, "_mem_req"},  64'(mem_req),       64'd0);
        check_eq({tag, "_mem_addr"}, mem_addr,           64'd0);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [5:0] atop);
        bit got = 1'b0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
        req.aw.size = size; req.aw.atop = atop; req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.aw_ready) got = 1'b1;
            @(negedge clk);
            if (got) break;
        end
        req.aw_valid = 1'b0;
        check_eq("aw_handshake", 64'(got), 64'd1);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
        bit got = 1'b0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
        req.ar.size = size; req.ar.burst = 2'b00;
        req.ar_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.ar_ready) got = 1'b1;
            @(negedge clk);
            if (got) break;
        end
        req.ar_valid = 1'b0;
        check_eq("ar_handshake", 64'(got), 64'd1);
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bit got = 1'b0;
        req.w.data = data; req.w.strb = strb; req.w.last = last;
        req.w_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.w_ready) got = 1'b1;
            @(negedge clk);
            if (got) break;
        end
        req.w_valid = 1'b0;
        check_eq("w_handshake", 64'(got), 64'd1);
    endtask

    task automatic recv_b(input logic [3:0] id, input logic [1:0] rsp, input bit stall);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.b_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("b_valid_seen", 64'(got), 64'd1);
        if (stall) begin
            @(negedge clk); #1;
            check_eq("b_stall_valid", 64'(resp.b_valid), 64'd1);
            check_eq("b_stall_resp",  64'(resp.b.resp),  64'(rsp));
        end
        check_eq("b_id",   64'(resp.b.id),   64'(id));
        check_eq("b_resp", 64'(resp.b.resp), 64'(rsp));
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
    endtask

    task automatic recv_r(input logic [3:0] id, input logic [63:0] data, input logic last,
                          input bit stall);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.r_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("r_valid_seen", 64'(got), 64'd1);
        if (stall) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); #1;
                check_eq("r_stall_valid", 64'(resp.r_valid), 64'd1);
                check_eq("r_stall_data",  resp.r.data,        data);
            end
        end
        check_eq("r_data", resp.r.data,        data);
        check_eq("r_id",   64'(resp.r.id),     64'(id));
        check_eq("r_resp", 64'(resp.r.resp),   64'(OKAY));
        check_eq("r_last", 64'(resp.r.last),   64'(last));
        req.r_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); rd_addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        req = '0;
        mem_gnt = 1'b1;
        mem_rdata = 64'd0;

        // Reset state, during and right after reset.
        repeat (2) @(negedge clk);
        #1;
        check_all_quiet("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_quiet("post_reset");
        @(negedge clk);

        // Single write at 0x1000.
        clear_logs();
        send_aw(4'd3, 64'h1000, 8'd0, 3'd3, 6'd0);
        #1;
        check_eq("wr_no_wvalid_req", 64'(mem_req), 64'd0);
        send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
        recv_b(4'd3, OKAY, 1'b1);
        check_eq("wr1_count", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() == 1) begin
            check_eq("wr1_addr", wr_addr_q[0], 64'h1000);
            check_eq("wr1_data", wr_data_q[0], 64'hDEAD_BEEF_0123_4567);
            check_eq("wr1_be",   64'(wr_be_q[0]), 64'hFF);
        end

        // 4-beat read at 0x2000 with r_ready stalls and latency checks.
        clear_logs();
        send_ar(4'd5, 64'h2000, 8'd3, 3'd3);
        #1;
        check_eq("rd_lat_req_n1", 64'(mem_req), 64'd1);
        check_eq("rd_lat_we",     64'(mem_we),  64'd0);
        check_eq("rd_lat_be",     64'(mem_be),  64'hFF);
        @(negedge clk); #1;
        check_eq("rd_lat_rvalid_n2", 64'(resp.r_valid), 64'd0);
        check_eq("rd_lat_req_n2",    64'(mem_req),      64'd0);
        @(negedge clk); #1;
        check_eq("rd_lat_rvalid_n3", 64'(resp.r_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            recv_r(4'd5, (64'h2000 + 64'(8 * i)) ^ RD_KEY, (i == 3), (i % 2 == 0));
        end
        check_eq("rd4_count", 64'(rd_addr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            check_eq("rd4_addr", rd_addr_q[i], 64'h2000 + 64'(8 * i));
        end

        // AW and AR together: write goes first.
        clear_logs();
        req.aw.id = 4'd1; req.aw.addr = 64'h5000; req.aw.len = 8'd0; req.aw.size = 3'd3;
        req.aw.atop = 6'd0;
        req.ar.id = 4'd2; req.ar.addr = 64'h6000; req.ar.len = 8'd0; req.ar.size = 3'd3;
        req.aw_valid = 1'b1; req.ar_valid = 1'b1;
        #1;
        check_eq("arb_aw_ready", 64'(resp.aw_ready), 64'd1);
        check_eq("arb_ar_ready", 64'(resp.ar_ready), 64'd0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        check_eq("arb_ar_blocked_wr", 64'(resp.ar_ready), 64'd0);
        send_w(64'h1111_2222_3333_4444, 8'h0F, 1'b1);
        #1;
        check_eq("arb_ar_blocked_b", 64'(resp.ar_ready), 64'd0);
        recv_b(4'd1, OKAY, 1'b0);
        #1;
        check_eq("arb_ar_after_b", 64'(resp.ar_ready), 64'd1);
        send_ar(4'd2, 64'h6000, 8'd0, 3'd3);
        recv_r(4'd2, 64'h6000 ^ RD_KEY, 1'b1, 1'b0);
        check_eq("arb_wr_count", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() == 1) begin
            check_eq("arb_wr_addr", wr_addr_q[0], 64'h5000);
            check_eq("arb_wr_be",   64'(wr_be_q[0]), 64'h0F);
        end

        // 2-beat write with w.last on the first beat -> SLVERR.
        clear_logs();
        send_aw(4'd4, 64'h7000, 8'd1, 3'd3, 6'd0);
        send_w(64'hAAAA, 8'hFF, 1'b1);
        send_w(64'hBBBB, 8'hFF, 1'b1);
        recv_b(4'd4, SLVERR, 1'b0);
        check_eq("lastmis_count", 64'(wr_addr_q.size()), 64'd2);
        if (wr_addr_q.size() == 2) begin
            check_eq("lastmis_addr0", wr_addr_q[0], 64'h7000);
            check_eq("lastmis_addr1", wr_addr_q[1], 64'h7008);
            check_eq("lastmis_data1", wr_data_q[1], 64'hBBBB);
        end

        // Grant withheld for 5 cycles; error flag must have cleared.
        clear_logs();
        send_aw(4'd6, 64'h8000, 8'd0, 3'd2, 6'd0);
        mem_gnt = 1'b0;
        req.w.data = 64'hCAFE; req.w.strb = 8'h0F; req.w.last = 1'b1; req.w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("gnt_stall_wready", 64'(resp.w_ready), 64'd0);
            check_eq("gnt_stall_req",    64'(mem_req),      64'd1);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        #1;
        check_eq("gnt_wready", 64'(resp.w_ready), 64'd1);
        @(negedge clk);
        req.w_valid = 1'b0;
        recv_b(4'd6, OKAY, 1'b0);
        check_eq("gnt_wr_count", 64'(wr_addr_q.size()), 64'd1);

        // Non-zero atop -> SLVERR.
        send_aw(4'd7, 64'h9000, 8'd0, 3'd3, 6'h20);
        send_w(64'h5555, 8'hFF, 1'b1);
        recv_b(4'd7, SLVERR, 1'b0);

        // Reset during beat 2 of a 4-beat read.
        send_ar(4'd9, 64'hA000, 8'd3, 3'd3);
        recv_r(4'd9, 64'hA000 ^ RD_KEY, 1'b0, 1'b0);
        recv_r(4'd9, 64'hA008 ^ RD_KEY, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (resp.r_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("rst_beat2_seen", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_quiet("rst_async");
        @(negedge clk); #1;
        check_all_quiet("rst_next");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_ar(4'd10, 64'hB000, 8'd0, 3'd3);
        recv_r(4'd10, 64'hB000 ^ RD_KEY, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slave_shim.md
AXI_SLAVE_SHIM -- requirements
Module: axi_slave_shim

Interface
REQ-001 The block SHALL have parameter AxiIdWidth, default 4: width of the AXI ID fields.
REQ-002 The block SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port axi_req_i, input, ariane_axi::req_t: AXI request from the upstream master.
REQ-005 The block SHALL have port axi_resp_o, output, ariane_axi::resp_t: AXI response to the upstream master.
REQ-006 The block SHALL have port mem_req_o, input-facing request strobe to memory, output, 1.
REQ-007 The block SHALL have port mem_gnt_i, input, 1: memory accepts the request this cycle.
REQ-008 The block SHALL have port mem_we_o, output, 1: 1 = write, 0 = read.
REQ-009 The block SHALL have port mem_addr_o, output, 64: byte address of the beat.
REQ-010 The block SHALL have port mem_wdata_o, output, 64: write data, taken from w.data.
REQ-011 The block SHALL have port mem_be_o, output, 8: byte enables, taken from w.strb; all ones for reads.
REQ-012 The block SHALL have port mem_rdata_i, input, 64: read data, valid exactly 1 cycle after a granted read.

Function
REQ-013 The block SHALL use the FSM states IDLE, WRITE, WRITE_RESP, READ, READ_WAIT and READ_RESP, and SHALL process one AXI transaction at a time.
REQ-014 In IDLE the block SHALL assert aw_ready when aw_valid is high, and SHALL assert ar_ready only when ar_valid is high and aw_valid is low.
REQ-015 When aw_valid and ar_valid are both high in IDLE, the write SHALL win.
REQ-016 On an AW handshake the block SHALL latch id, addr, len, size and atop into internal registers, clear the beat counter, and enter WRITE.
REQ-017 On an AR handshake the block SHALL latch id, addr, len and size into internal registers, clear the beat counter, and enter READ.
REQ-018 In WRITE: mem_req_o = w_valid, mem_we_o = 1, and w_ready = w_valid & mem_gnt_i (one beat per granted cycle).
REQ-019 On each W beat, the address register SHALL advance by (1 << size), the counter SHALL increment, and on the beat where counter == len the FSM SHALL go to WRITE_RESP.
REQ-020 The beat counter (8 bit), not w.last, SHALL terminate a write burst.
REQ-021 If w.last disagrees with (counter == len) on any beat, the block SHALL set a sticky error flag.
REQ-022 In WRITE_RESP: b_valid = 1, b.id = latched id, b.resp = SLVERR if the error flag is set or atop != 0, else OKAY; on b_ready the FSM SHALL return to IDLE and clear the flag.
REQ-023 In READ: mem_req_o = 1, mem_we_o = 0; on mem_gnt_i the FSM SHALL go to READ_WAIT.
REQ-024 In READ_WAIT the block SHALL capture mem_rdata_i into a 64-bit holding register and go to READ_RESP.
REQ-025 In READ_RESP: r_valid = 1, r.data = holding register, r.id = latched id, r.resp = OKAY, r.last = (counter == len).
REQ-026 On r_ready in READ_RESP: if last, the FSM SHALL go to IDLE; else the address SHALL advance by (1 << size), the counter SHALL increment, and the FSM SHALL go to READ.
REQ-027 Read latency SHALL be: AR handshake in cycle N, mem_req_o in N+1, r_valid no earlier than N+3 (grant in N+1).
REQ-028 burst FIXED and WRAP SHALL be treated as INCR.
REQ-029 lock SHALL be ignored; EXOKAY SHALL never be returned.
REQ-030 Address increment SHALL be computed in 64 bits with natural wrap-around.
REQ-031 Outputs that are not driven by the current state SHALL be 0.
REQ-032 r/b payloads SHALL remain stable while their valid is high and ready is low.

Reset
REQ-033 On rst_ni low, at any time including mid-burst, the FSM SHALL go to IDLE, and the counter, error flag, address/len/id registers and holding register SHALL clear to 0 asynchronously.
REQ-034 Out of reset, all ready/valid outputs and mem_req_o SHALL be 0.
REQ-035 Out of reset, an in-flight transaction SHALL be abandoned without a response.

Verification
REQ-036 Scenario: single write, addr 0x1000, len 0, strb 0xFF, mem_gnt_i always 1 -> one mem write at 0x1000, then b_valid with resp OKAY and id echoed.
REQ-037 Scenario: 4-beat read, addr 0x2000, size 3, r_ready toggling -> mem reads at 0x2000/08/10/18, four R beats in order, r.last only on the 4th, data stable while stalled.
REQ-038 Scenario: aw_valid and ar_valid asserted in the same cycle -> write completes first (B observed), then AR is accepted.
REQ-039 Scenario: 2-beat write (len 1) with w.last on beat 0 -> two mem writes, b.resp = SLVERR.
REQ-040 Scenario: mem_gnt_i held low 5 cycles during a write -> w_ready stays 0 and mem_req_o stays 1 until the grant.
REQ-041 Scenario: rst_ni asserted during beat 2 of a 4-beat read -> all outputs 0 the next cycle, and a fresh AR is accepted normally after release.
